ic_refill_responder: RTL and testbench

Memory-side responder for the L1 instruction-cache miss interface. It accepts a block-address refill request from the I-cache controller, gathers the line from the backing memory port as a sequence of fixed-width beats, and returns tag, index and the full line with a one-cycle valid. It also forwards external snoop invalidations to the I-cache, and re-issues any invalidation that races an in-flight fill. It sits between the I-cache controller and the memory/L2 interface, opposite the I-cache's request port.

---
 rtl/ic_refill_pkg.sv | 25 ++
 rtl/ic_refill_responder_if.sv | 50 +++++
 rtl/ic_req_fifo.sv | 59 +++++
 rtl/ic_refill_responder.sv | 165 ++++++++++++++++
 tb/tb_ic_refill_responder.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ic_refill_pkg.sv
// rtl/ic_refill_pkg.sv - shared geometry, FSM states and request type for the I-cache refill responder
package ic_refill_pkg;

    localparam int ICACHE_BLOCK_ADDR_BITS = 16;
    localparam int ICACHE_INDEX_BITS      = 6;
    localparam int ICACHE_BITS_IN_LINE    = 256;
    localparam int ICACHE_BEAT_BITS       = 64;

    localparam int BEATS    = ICACHE_BITS_IN_LINE / ICACHE_BEAT_BITS;
    localparam int BEAT_LOG = $clog2(BEATS);
    localparam int TAG_BITS = ICACHE_BLOCK_ADDR_BITS - ICACHE_INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } refill_state_t;

    typedef struct packed {
        logic [ICACHE_BLOCK_ADDR_BITS-1:0] block;
        logic [1:0]                        way;
    } refill_req_t;

endpackage

// File: rtl/ic_refill_responder_if.sv
// rtl/ic_refill_responder_if.sv - I-cache miss, memory beat and snoop signals of the refill responder
interface ic_refill_responder_if
    import ic_refill_pkg::*;
#(
    parameter int BLOCK_ADDR_BITS = ICACHE_BLOCK_ADDR_BITS,
    parameter int INDEX_BITS      = ICACHE_INDEX_BITS,
    parameter int LINE_BITS       = ICACHE_BITS_IN_LINE,
    parameter int BEAT_BITS       = ICACHE_BEAT_BITS
);
    localparam int IF_TAG_BITS  = BLOCK_ADDR_BITS - INDEX_BITS;
    localparam int IF_BEAT_LOG  = $clog2(LINE_BITS / BEAT_BITS);

    logic [BLOCK_ADDR_BITS-1:0]             ic2memReqAddr_i;
    logic                                   ic2memReqValid_i;
    logic [1:0]                             ic2memReqWay_i;
    logic [IF_TAG_BITS-1:0]                 mem2icTag_o;
    logic [INDEX_BITS-1:0]                  mem2icIndex_o;
    logic [LINE_BITS-1:0]                   mem2icData_o;
    logic                                   mem2icRespValid_o;
    logic                                   mem2icInv_o;
    logic [INDEX_BITS-1:0]                  mem2icInvInd_o;
    logic [1:0]                             mem2icInvWay_o;
    logic [BLOCK_ADDR_BITS+IF_BEAT_LOG-1:0] memReqAddr_o;
    logic                                   memReqValid_o;
    logic                                   memReqReady_i;
    logic [BEAT_BITS-1:0]                   memRspData_i;
    logic                                   memRspValid_i;
    logic                                   snoopInv_i;
    logic [INDEX_BITS-1:0]                  snoopIndex_i;
    logic                                   overflow_o;

    modport master (
        input  ic2memReqAddr_i, ic2memReqValid_i, ic2memReqWay_i,
        input  memReqReady_i, memRspData_i, memRspValid_i,
        input  snoopInv_i, snoopIndex_i,
        output mem2icTag_o, mem2icIndex_o, mem2icData_o, mem2icRespValid_o,
        output mem2icInv_o, mem2icInvInd_o, mem2icInvWay_o,
        output memReqAddr_o, memReqValid_o, overflow_o
    );

    modport slave (
        output ic2memReqAddr_i, ic2memReqValid_i, ic2memReqWay_i,
        output memReqReady_i, memRspData_i, memRspValid_i,
        output snoopInv_i, snoopIndex_i,
        input  mem2icTag_o, mem2icIndex_o, mem2icData_o, mem2icRespValid_o,
        input  mem2icInv_o, mem2icInvInd_o, mem2icInvWay_o,
        input  memReqAddr_o, memReqValid_o, overflow_o
    );

endinterface

// File: rtl/ic_req_fifo.sv
// rtl/ic_req_fifo.sv - synchronous request FIFO; a push on full is accepted when a pop frees a slot in the same cycle
module ic_req_fifo
    import ic_refill_pkg::*;
#(
    parameter type T     = refill_req_t,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_push_data,
    input  logic i_pop,
    output T     o_pop_data,
    output logic o_full,
    output logic o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ic_refill_responder.sv
// rtl/ic_refill_responder.sv - gathers I-cache miss lines beat by beat from memory and forwards snoop invalidates
module ic_refill_responder
    import ic_refill_pkg::*;
#(
    parameter int BLOCK_ADDR_BITS = ICACHE_BLOCK_ADDR_BITS,
    parameter int INDEX_BITS      = ICACHE_INDEX_BITS,
    parameter int LINE_BITS       = ICACHE_BITS_IN_LINE,
    parameter int BEAT_BITS       = ICACHE_BEAT_BITS,
    parameter int FIFO_DEPTH      = 2
) (
    input logic                   clk,
    input logic                   reset,
    ic_refill_responder_if.master bus
);
    localparam int FILL_BEATS    = LINE_BITS / BEAT_BITS;
    localparam int FILL_BEAT_LOG = $clog2(FILL_BEATS);

    typedef struct packed {
        logic [BLOCK_ADDR_BITS-1:0] block;
        logic [1:0]                 way;
    } req_t;

    refill_state_t              r_state;
    refill_state_t              w_next_state;
    req_t                       w_push_data;
    req_t                       w_fifo_head;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic                       w_pop;
    logic                       w_beat_done;
    logic                       w_last_beat;
    logic [BLOCK_ADDR_BITS-1:0] r_fill_block;
    logic [1:0]                 r_fill_way_unused;
    logic [FILL_BEAT_LOG-1:0]   r_beat;
    logic [LINE_BITS-1:0]       r_line;
    logic                       r_req_valid;
    logic                       r_resp_valid;
    logic                       r_overflow;
    logic                       r_inv;
    logic [INDEX_BITS-1:0]      r_inv_idx;
    logic                       r_pend;
    logic                       r_reissue_defer;
    logic [INDEX_BITS-1:0]      r_pend_idx;
    logic [INDEX_BITS-1:0]      w_fill_idx;
    logic                       w_snoop_hit;
    logic                       w_reissue_due;

    assign w_push_data = {bus.ic2memReqAddr_i, bus.ic2memReqWay_i};

    ic_req_fifo #(
        .T     (req_t),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_push      (bus.ic2memReqValid_i),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign w_last_beat = (r_beat == FILL_BEAT_LOG'(FILL_BEATS - 1));

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_beat_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.memReqReady_i) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.memRspValid_i) begin
                    w_beat_done  = 1'b1;
                    w_next_state = w_last_beat ? ST_RESP : ST_REQ;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= ST_IDLE;
            r_req_valid       <= 1'b0;
            r_resp_valid      <= 1'b0;
            r_fill_block      <= '0;
            r_fill_way_unused <= '0;
            r_beat            <= '0;
            r_line            <= '0;
            r_overflow        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_req_valid  <= (w_next_state == ST_REQ);
            r_resp_valid <= (w_next_state == ST_RESP);
            if (w_pop) begin
                r_fill_block      <= w_fifo_head.block;
                r_fill_way_unused <= w_fifo_head.way;
                r_beat            <= '0;
            end else if (w_beat_done && !w_last_beat) begin
                r_beat <= r_beat + FILL_BEAT_LOG'(1);
            end
            for (int k = 0; k < FILL_BEATS; k++) begin
                if (w_beat_done && (r_beat == FILL_BEAT_LOG'(k))) begin
                    r_line[k*BEAT_BITS +: BEAT_BITS] <= bus.memRspData_i;
                end
            end
            if (bus.ic2memReqValid_i && w_fifo_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign w_fill_idx    = r_fill_block[INDEX_BITS-1:0];
    assign w_snoop_hit   = bus.snoopInv_i && (r_state != ST_IDLE) && (bus.snoopIndex_i == w_fill_idx);
    assign w_reissue_due = ((r_state == ST_RESP) && (r_pend || w_snoop_hit)) || r_reissue_defer;

    // A fresh snoop always wins the invalidate port; a displaced re-issue retries next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inv           <= 1'b0;
            r_inv_idx       <= '0;
            r_pend          <= 1'b0;
            r_pend_idx      <= '0;
            r_reissue_defer <= 1'b0;
        end else begin
            if (bus.snoopInv_i) begin
                r_inv     <= 1'b1;
                r_inv_idx <= bus.snoopIndex_i;
            end else if (w_reissue_due) begin
                r_inv     <= 1'b1;
                r_inv_idx <= r_reissue_defer ? r_pend_idx : w_fill_idx;
            end else begin
                r_inv <= 1'b0;
            end
            r_reissue_defer <= w_reissue_due && bus.snoopInv_i;
            if (r_state == ST_RESP) begin
                r_pend <= 1'b0;
            end else if (w_snoop_hit) begin
                r_pend <= 1'b1;
            end
            if (w_snoop_hit && !r_reissue_defer) r_pend_idx <= w_fill_idx;
        end
    end

    assign bus.mem2icTag_o       = r_fill_block[BLOCK_ADDR_BITS-1:INDEX_BITS];
    assign bus.mem2icIndex_o     = w_fill_idx;
    assign bus.mem2icData_o      = r_line;
    assign bus.mem2icRespValid_o = r_resp_valid;
    assign bus.mem2icInv_o       = r_inv;
    assign bus.mem2icInvInd_o    = r_inv_idx;
    assign bus.mem2icInvWay_o    = 2'b00;
    assign bus.memReqAddr_o      = {r_fill_block, r_beat};
    assign bus.memReqValid_o     = r_req_valid;
    assign bus.overflow_o        = r_overflow;

endmodule

// File: tb/tb_ic_refill_responder.sv
// tb/tb_ic_refill_responder.sv - directed self-checking bench for ic_refill_responder
module tb_ic_refill_responder;

    logic clk;
    logic reset;

    ic_refill_responder_if bus ();

    ic_refill_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [9:0]    tag;
        logic [5:0]    idx;
        logic [255:0]  data;
    } resp_t;

    typedef struct {
        int         cyc;
        logic [5:0] idx;
    } inv_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t0;
    int          first_req_cyc;
    int          stall_left = 0;
    logic [17:0] stall_addr_exp = '0;
    bit          mem_en = 1'b1;
    resp_t       resp_q [$];
    inv_t        inv_q [$];
    logic [17:0] acc_q [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_word(input logic [17:0] a);
        return {38'd0, a, 8'hA0 + {6'd0, a[1:0]}};
    endfunction

    function automatic logic [255:0] exp_line(input logic [15:0] blk);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = beat_word({blk, 2'(k)});
        return l;
    endfunction

    task automatic clear_logs();
        resp_q.delete();
        inv_q.delete();
        acc_q.delete();
        first_req_cyc = -1;
    endtask

    // One clock: memory answers each accepted beat in the following cycle.
    task automatic tick();
        logic        acc;
        logic [17:0] a;
        resp_t       r;
        inv_t        v;
        acc = bus.memReqValid_o && bus.memReqReady_i;
        a   = bus.memReqAddr_o;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) acc_q.push_back(a);
        if (mem_en) begin
            bus.memRspValid_i = acc;
            bus.memRspData_i  = acc ? beat_word(a) : 64'd0;
        end
        bus.ic2memReqValid_i = 1'b0;
        bus.snoopInv_i       = 1'b0;
        if (bus.mem2icRespValid_o) begin
            r.cyc = cyc; r.tag = bus.mem2icTag_o; r.idx = bus.mem2icIndex_o; r.data = bus.mem2icData_o;
            resp_q.push_back(r);
        end
        if (bus.mem2icInv_o) begin
            v.cyc = cyc; v.idx = bus.mem2icInvInd_o;
            inv_q.push_back(v);
        end
        if (bus.memReqValid_o && first_req_cyc < 0) first_req_cyc = cyc;
        if (stall_left > 0 && bus.memReqValid_o && bus.memReqAddr_o[1:0] == 2'd2) begin
            check("stall_addr", bus.memReqAddr_o, stall_addr_exp);
            bus.memReqReady_i = 1'b0;
            stall_left--;
        end else begin
            bus.memReqReady_i = 1'b1;
        end
    endtask

    task automatic pulse(input logic [15:0] blk);
        bus.ic2memReqAddr_i  = blk;
        bus.ic2memReqWay_i   = blk[1:0];
        bus.ic2memReqValid_i = 1'b1;
    endtask

    task automatic snoop(input logic [5:0] idx);
        bus.snoopIndex_i = idx;
        bus.snoopInv_i   = 1'b1;
    endtask

    task automatic wait_resp(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (resp_q.size() < n && b > 0) begin
            tick();
            b--;
        end
        check({tag, "_resp_count"}, resp_q.size(), n);
    endtask

    initial begin
        reset                = 1'b0;
        bus.ic2memReqAddr_i  = '0;
        bus.ic2memReqValid_i = 1'b0;
        bus.ic2memReqWay_i   = '0;
        bus.memReqReady_i    = 1'b1;
        bus.memRspData_i     = '0;
        bus.memRspValid_i    = 1'b0;
        bus.snoopInv_i       = 1'b0;
        bus.snoopIndex_i     = '0;
        clear_logs();

        repeat (3) tick();
        check("rst_req_valid", bus.memReqValid_o, 0);
        check("rst_req_addr", bus.memReqAddr_o, 0);
        check("rst_resp_valid", bus.mem2icRespValid_o, 0);
        check("rst_data", bus.mem2icData_o, 0);
        check("rst_tag", bus.mem2icTag_o, 0);
        check("rst_index", bus.mem2icIndex_o, 0);
        check("rst_inv", bus.mem2icInv_o, 0);
        check("rst_inv_ind", bus.mem2icInvInd_o, 0);
        check("rst_inv_way", bus.mem2icInvWay_o, 0);
        check("rst_overflow", bus.overflow_o, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Single miss at 0x1234
        clear_logs();
        t0 = cyc;
        pulse(16'h1234);
        wait_resp(1, 40, "t1");
        check("t1_first_req_cycle", first_req_cyc - t0, 2);
        check("t1_acc_count", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            check("t1_addr0", acc_q[0], 18'h048D0);
            check("t1_addr1", acc_q[1], 18'h048D1);
            check("t1_addr2", acc_q[2], 18'h048D2);
            check("t1_addr3", acc_q[3], 18'h048D3);
        end
        if (resp_q.size() > 0) begin
            check("t1_resp_cycle", resp_q[0].cyc - t0, 10);
            check("t1_tag", resp_q[0].tag, 10'h048);
            check("t1_index", resp_q[0].idx, 6'h34);
            check("t1_data", resp_q[0].data,
                  {64'h000000000048D3A3, 64'h000000000048D2A2,
                   64'h000000000048D1A1, 64'h000000000048D0A0});
        end
        repeat (4) tick();

        // Ready held low for 5 cycles on beat 2
        clear_logs();
        stall_left     = 5;
        stall_addr_exp = 18'h091A2;
        t0 = cyc;
        pulse(16'h2468);
        wait_resp(1, 60, "t2");
        check("t2_stall_used", stall_left, 0);
        if (resp_q.size() > 0) begin
            check("t2_resp_cycle", resp_q[0].cyc - t0, 15);
            check("t2_tag", resp_q[0].tag, 10'h091);
            check("t2_index", resp_q[0].idx, 6'h28);
            check("t2_data", resp_q[0].data, exp_line(16'h2468));
        end
        repeat (4) tick();

        // Three pulses while busy: two queue, third overflows
        clear_logs();
        t0 = cyc;
        pulse(16'h0100);
        repeat (3) tick();
        pulse(16'h0201);
        tick();
        pulse(16'h0302);
        tick();
        pulse(16'h0403);
        tick();
        wait_resp(3, 80, "t3");
        repeat (20) tick();
        check("t3_resp_total", resp_q.size(), 3);
        check("t3_overflow", bus.overflow_o, 1);
        if (resp_q.size() >= 3) begin
            check("t3_a_cycle", resp_q[0].cyc - t0, 10);
            check("t3_a_tag", resp_q[0].tag, 10'h004);
            check("t3_b_cycle", resp_q[1].cyc - t0, 20);
            check("t3_b_tag", resp_q[1].tag, 10'h008);
            check("t3_b_index", resp_q[1].idx, 6'h01);
            check("t3_b_data", resp_q[1].data, exp_line(16'h0201));
            check("t3_c_cycle", resp_q[2].cyc - t0, 30);
            check("t3_c_tag", resp_q[2].tag, 10'h00C);
            check("t3_c_index", resp_q[2].idx, 6'h02);
        end

        // Snoop hitting the in-flight fill during WAIT
        clear_logs();
        t0 = cyc;
        pulse(16'h0ABC);
        repeat (3) tick();
        snoop(6'h3C);
        wait_resp(1, 40, "t4a");
        repeat (3) tick();
        check("t4a_inv_count", inv_q.size(), 2);
        if (resp_q.size() > 0) check("t4a_resp_cycle", resp_q[0].cyc - t0, 10);
        if (inv_q.size() == 2) begin
            check("t4a_inv0_cycle", inv_q[0].cyc - t0, 4);
            check("t4a_inv0_idx", inv_q[0].idx, 6'h3C);
            check("t4a_inv1_cycle", inv_q[1].cyc - t0, 11);
            check("t4a_inv1_idx", inv_q[1].idx, 6'h3C);
        end

        // Non-matching snoop gives a single invalidate
        clear_logs();
        t0 = cyc;
        pulse(16'h0A55);
        repeat (3) tick();
        snoop(6'h07);
        wait_resp(1, 40, "t4b");
        repeat (3) tick();
        check("t4b_inv_count", inv_q.size(), 1);
        if (inv_q.size() > 0) begin
            check("t4b_inv_cycle", inv_q[0].cyc - t0, 4);
            check("t4b_inv_idx", inv_q[0].idx, 6'h07);
        end

        // New snoop in the RESP cycle pushes the re-issue back one cycle
        clear_logs();
        t0 = cyc;
        pulse(16'h0040);
        repeat (5) tick();
        snoop(6'h00);
        repeat (5) tick();
        snoop(6'h11);
        repeat (5) tick();
        check("t4c_resp_count", resp_q.size(), 1);
        if (resp_q.size() > 0) check("t4c_resp_cycle", resp_q[0].cyc - t0, 10);
        check("t4c_inv_count", inv_q.size(), 3);
        if (inv_q.size() == 3) begin
            check("t4c_inv0_cycle", inv_q[0].cyc - t0, 6);
            check("t4c_inv0_idx", inv_q[0].idx, 6'h00);
            check("t4c_inv1_cycle", inv_q[1].cyc - t0, 11);
            check("t4c_inv1_idx", inv_q[1].idx, 6'h11);
            check("t4c_inv2_cycle", inv_q[2].cyc - t0, 12);
            check("t4c_inv2_idx", inv_q[2].idx, 6'h00);
        end
        check("t4_overflow_sticky", bus.overflow_o, 1);

        // Reset during WAIT of beat 2, then a stray beat after release
        clear_logs();
        t0 = cyc;
        pulse(16'h0777);
        repeat (7) tick();
        reset = 1'b0;
        #1;
        check("t5_req_valid", bus.memReqValid_o, 0);
        check("t5_req_addr", bus.memReqAddr_o, 0);
        check("t5_data", bus.mem2icData_o, 0);
        check("t5_tag", bus.mem2icTag_o, 0);
        check("t5_index", bus.mem2icIndex_o, 0);
        check("t5_overflow", bus.overflow_o, 0);
        mem_en            = 1'b0;
        bus.memRspValid_i = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        clear_logs();
        bus.memRspValid_i = 1'b1;
        bus.memRspData_i  = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        bus.memRspValid_i = 1'b0;
        repeat (20) tick();
        check("t5_no_resp", resp_q.size(), 0);
        check("t5_no_req", first_req_cyc, -1);
        check("t5_data_after", bus.mem2icData_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
